apb2axi_req_fifo: RTL and testbench

APB2AXI_REQ_FIFO -- requirements
Module: apb2axi_req_fifo

---
 rtl/apb2axi_req_fifo.sv | 75 +++++++
 tb/tb_apb2axi_req_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_req_fifo.sv
// Request FIFO between the APB transaction manager and an AXI channel master.
// First-word-fall-through register FIFO with wrap-bit pointers, a registered
// full/empty view (no combinational ready paths) and sticky misuse flags.
module apb2axi_req_fifo #(
  parameter int REQ_WIDTH    = 64,
  parameter int FIFO_ENTRY_W = REQ_WIDTH,
  parameter int DEPTH        = 8,
  parameter int AF_THRESH    = DEPTH - 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [FIFO_ENTRY_W-1:0]      push_data,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [FIFO_ENTRY_W-1:0]      pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [FIFO_ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW-1:0]           ptr_diff;
  logic                    empty, full;
  logic                    push_acc, pop_acc;

  // Status comes only from the pointer registers, so push_ready never
  // depends on pop_ready: a full FIFO refuses a push even when popped.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign push_acc   = push_valid && !full;
  assign pop_acc    = pop_ready && !empty;

  assign pop_data    = mem[rd_ptr[AW-1:0]];
  assign ptr_diff    = wr_ptr - rd_ptr;
  assign count       = ptr_diff[CW-1:0];
  assign almost_full = (int'(count) >= AF_THRESH);

  // Storage write; the array is intentionally left unreset.
  always_ff @(posedge aclk) begin
    if (push_acc) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer advance; the wrap bit rolls naturally modulo 2*DEPTH.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Sticky error flags: refused push and pop of an empty FIFO.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push_valid && full) err_overflow  <= 1'b1;
      if (pop_ready && empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb2axi_req_fifo.sv
// Directed bench for apb2axi_req_fifo at DEPTH=4, AF_THRESH=3, 8-bit entries.
module tb_apb2axi_req_fifo;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [7:0] push_data = '0;
  logic       pop_valid;
  logic       pop_ready = 1'b0;
  logic [7:0] pop_data;
  logic [2:0] count;
  logic       almost_full;
  logic       err_overflow;
  logic       err_underflow;

  int vectors = 0;
  int miscompares = 0;

  apb2axi_req_fifo #(.FIFO_ENTRY_W(8), .DEPTH(4), .AF_THRESH(3)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .almost_full(almost_full),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(); tick();
    vectors++; if (push_ready !== 1'b1) begin miscompares++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
    vectors++; if (pop_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pop_valid got %b want 0", pop_valid); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
    vectors++; if ({err_overflow, err_underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b want 00", {err_overflow, err_underflow}); end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [2:0] ecnt;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1; push_data = vals[i];
      tick();
      push_valid = 1'b0;
      ecnt = 3'(i + 1);
      vectors++; if (count !== ecnt) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, ecnt); end
      vectors++; if (almost_full !== (i >= 2)) begin miscompares++; $display("FAIL fill_almost_full[%0d] got %b want %b", i, almost_full, (i >= 2)); end
      vectors++; if (push_ready !== (i < 3)) begin miscompares++; $display("FAIL fill_push_ready[%0d] got %b want %b", i, push_ready, (i < 3)); end
    end
    // Head must hold while the consumer stalls.
    tick(); tick();
    vectors++; if (pop_data !== 8'h11) begin miscompares++; $display("FAIL stall_hold got %h want 11", pop_data); end
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (pop_valid !== 1'b1 || pop_data !== vals[i]) begin miscompares++; $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, pop_valid, pop_data, vals[i]); end
      tick();
    end
    pop_ready = 1'b0;
    vectors++; if (pop_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL drain_empty got v=%b c=%0d want v=0 c=0", pop_valid, count); end
    vectors++; if ({err_overflow, err_underflow} !== 2'b00) begin miscompares++; $display("FAIL fill_no_err got %b want 00", {err_overflow, err_underflow}); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] vals [4] = '{8'hA1, 8'hA2, 8'hA3, 8'h55};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1; push_data = 8'(8'hA0 + i);
      tick();
    end
    push_valid = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d want 4", count); end
    push_valid = 1'b1; push_data = 8'h55; pop_ready = 1'b1;
    #1;
    vectors++; if (pop_data !== 8'hA0) begin miscompares++; $display("FAIL full_head got %h want a0", pop_data); end
    tick();
    vectors++; if (err_overflow !== 1'b1) begin miscompares++; $display("FAIL full_overflow got %b want 1", err_overflow); end
    vectors++; if (count !== 3'd3 || push_ready !== 1'b1) begin miscompares++; $display("FAIL full_after_pop got c=%0d r=%b want c=3 r=1", count, push_ready); end
    pop_ready = 1'b0;
    tick();
    push_valid = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_repush_count got %0d want 4", count); end
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (pop_data !== vals[i]) begin miscompares++; $display("FAIL full_order[%0d] got %h want %h", i, pop_data, vals[i]); end
      tick();
    end
    pop_ready = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL full_final_count got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_data = 8'(8'hB0 + i); q.push_back(push_data);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      push_valid = 1'b1; push_data = 8'(i); pop_ready = 1'b1;
      #1;
      exp_d = q.pop_front();
      q.push_back(push_data);
      vectors++; if (pop_data !== exp_d) begin miscompares++; $display("FAIL wrap_data[%0d] got %h want %h", i, pop_data, exp_d); end
      tick();
      vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL wrap_count[%0d] got %0d want 3", i, count); end
    end
    push_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_d = q.pop_front();
      vectors++; if (pop_valid !== 1'b1 || pop_data !== exp_d) begin miscompares++; $display("FAIL wrap_drain[%0d] got v=%b d=%h want v=1 d=%h", i, pop_valid, pop_data, exp_d); end
      tick();
    end
    pop_ready = 1'b0;
    vectors++; if (pop_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty got %b want 0", pop_valid); end
  endtask

  task automatic test_latency_underflow();
    apply_reset();
    push_valid = 1'b1; push_data = 8'hA5; pop_ready = 1'b1;
    #1;
    vectors++; if (pop_valid !== 1'b0) begin miscompares++; $display("FAIL lat_n got %b want 0", pop_valid); end
    tick();
    push_valid = 1'b0;
    vectors++; if (pop_valid !== 1'b1 || pop_data !== 8'hA5) begin miscompares++; $display("FAIL lat_n1 got v=%b d=%h want v=1 d=a5", pop_valid, pop_data); end
    tick();
    pop_ready = 1'b0;
    vectors++; if (pop_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL lat_n2 got v=%b c=%0d want v=0 c=0", pop_valid, count); end
    vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_set got %b want 1", err_underflow); end
    // Normal traffic must not clear the sticky flag.
    push_valid = 1'b1; push_data = 8'h01; tick(); push_valid = 1'b0;
    pop_ready = 1'b1; tick(); pop_ready = 1'b0;
    tick();
    vectors++; if (err_underflow !== 1'b1 || err_overflow !== 1'b0) begin miscompares++; $display("FAIL underflow_sticky got u=%b o=%b want u=1 o=0", err_underflow, err_overflow); end
    apply_reset();
    vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL underflow_clear got %b want 0", err_underflow); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    push_valid = 1'b1; push_data = 8'hC1; tick();
    push_data = 8'hC2; tick();
    push_valid = 1'b0;
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL mid_pre_count got %0d want 2", count); end
    #2 aresetn = 1'b0;
    #1;
    vectors++; if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin miscompares++; $display("FAIL mid_async got c=%0d v=%b r=%b want c=0 v=0 r=1", count, pop_valid, push_ready); end
    @(posedge aclk);
    #3 aresetn = 1'b1;
    tick();
    push_valid = 1'b1; push_data = 8'h77; tick();
    push_valid = 1'b0;
    vectors++; if (pop_valid !== 1'b1 || pop_data !== 8'h77 || count !== 3'd1) begin miscompares++; $display("FAIL mid_first got v=%b d=%h c=%0d want v=1 d=77 c=1", pop_valid, pop_data, count); end
    pop_ready = 1'b1; tick(); pop_ready = 1'b0;
    vectors++; if (pop_valid !== 1'b0) begin miscompares++; $display("FAIL mid_drain got %b want 0", pop_valid); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_wrap();
    test_latency_underflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
